shared_pipe_arbiter: RTL and testbench
======================================

Name: shared_pipe_arbiter

Overview:
- Parametrised successor to the two-pipeline arbiter/shared-resource wrapper.
- Accepts NUM_CH independent producer channels and arbitrates them round-robin into one shared DEPTH-stage compute pipeline.
- Each stage entry carries a channel tag, so per-channel flush and per-channel output steering are possible.
- Sits between the producer FSM and the consumer FSM; drives per-channel stall back to the producer.

Parameters:
NUM_CH, 2, number of producer/consumer channels (2..8)
DATA_W, 32, data width per channel
DEPTH, 3, register stages in the shared resource (1..8)
ADD_CONST, 1, constant added by the shared resource

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  channel i presents data
flush  input  NUM_CH  kill channel i's in-flight work
stall  output  NUM_CH  channel i not accepted this cycle; producer holds data
out_data  output  NUM_CH*DATA_W  per-channel result, registered
out_valid  output  NUM_CH  one-cycle pulse per result
busy  output  1  any pipeline stage valid

Behaviour:
- Reset (synchronous, active-high, sampled at the clk edge):
  - rr_ptr=0; all stage valids 0; out_valid=0; out_data=0; busy=0.
  - Reset mid-operation discards all in-flight entries; nothing emerges afterwards.
- Eligibility: eligible[i] = in_valid[i] & ~flush[i].
- Arbitration: combinational round-robin.
  - Search starts at rr_ptr and wraps modulo NUM_CH; at most one grant per cycle.
  - On a grant to channel g, rr_ptr <= (g+1) mod NUM_CH. With no grant, rr_ptr holds.
- Stall: stall[i] = eligible[i] & ~grant[i], purely combinational.
  - A flushed channel never stalls; its input is dropped.
- Acceptance: a granted input is captured into stage 1 as {valid=1, tag=g, data=in_data[g]+ADD_CONST}.
  - The add is modulo 2^DATA_W; carry is discarded.
- Pipeline: the shared pipeline never stalls; entries advance one stage per cycle.
  - Latency: input accepted at edge t -> out_valid[tag] high during the cycle after edge t+DEPTH-1. For DEPTH=3, a grant in cycle 0 gives out_valid in cycle 3.
- Output: on the edge where the last stage holds a valid entry with tag k:
  - out_data[k] <= data; out_valid[k] <= 1.
  - The other channels' out_valid <= 0; their out_data holds its previous value.
  - The consumer has no backpressure.
- Flush:
  - flush[i] high at an edge clears the valid bit of every stage entry tagged i, including the entry that would land in the output register that edge, so out_valid[i] stays 0 next cycle.
  - Entries of other channels are unaffected.
  - An input from channel i is not accepted in a cycle where flush[i] is high.
- Simultaneous events:
  - Flush of channel i in the same cycle channel j is granted: j's entry enters normally.
  - All channels valid: each channel is granted exactly once every NUM_CH cycles.
- busy = OR of all stage valid bits (registered stages only).

Optional Feature:
- Macro: SHARED_PIPE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, width NUM_CH*16: one 16-bit counter per channel.
  - Channel i's counter increments on every cycle with stall[i]=1 and saturates at 16'hFFFF (no wrap).
  - Counters are cleared by reset only.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=all ones -> stall=0 during reset, out_valid=0, busy=0, rr_ptr=0 after release.
- Single channel, DEPTH=3: ch0 in_data=0x10, valid 1 cycle at cycle 0 -> stall[0]=0; out_valid[0] pulses in cycle 3 only; out_data[0]=0x11.
- Contention: ch0=0xA and ch1=0xB both valid from cycle 0 and held while stalled -> grant order ch0 then ch1; stall[1]=1 in cycle 0 only; out_data[0]=0xB in cycle 3; out_data[1]=0xC in cycle 4.
- Flush mid-flight: accept ch1=0x5 in cycle 0, flush[1]=1 in cycle 1 -> no out_valid[1] pulse ever; a ch0 entry accepted in cycle 1 still emerges in cycle 4.
- Same-cycle flush and valid on ch0 -> stall[0]=0, nothing accepted, busy stays 0. Wrap case: in_data=0xFFFFFFFF -> out_data=0x00000000.
- Reset mid-operation: 3 entries in flight, assert reset -> no out_valid afterwards. With SHARED_PIPE_STALL_CNT_EN, 5 stalled cycles on ch1 -> stall_cnt[1]=5, and reset returns it to 0.

Source files
------------

// File: rtl/shared_pipe_arbiter.sv
// rtl/shared_pipe_arbiter.sv - round-robin arbiter feeding one shared tagged add pipeline
// Optional per-channel stall counters: define SHARED_PIPE_STALL_CNT_EN.
module shared_pipe_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 3,
  parameter int ADD_CONST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH-1:0]          flush,
  output logic [NUM_CH-1:0]          stall,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic [NUM_CH-1:0]          out_valid,
  output logic                       busy
`ifdef SHARED_PIPE_STALL_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]       stall_cnt
`endif
);

  localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // The output register is the last of the DEPTH stages, so DEPTH-1 internal stages remain.
  localparam int NS    = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [TAG_W-1:0]          r_rr_ptr;
  logic [NUM_CH-1:0]         w_elig;
  logic [2*NUM_CH-1:0]       w_rot;
  logic [NUM_CH-1:0]         w_grant;
  logic                      w_any_grant;
  logic [TAG_W:0]            w_pos;
  logic [TAG_W-1:0]          w_gnt_idx;
  logic [DATA_W-1:0]         w_gnt_data;
  logic [DATA_W-1:0]         w_gnt_sum;

  logic [NS-1:0]             r_vld;
  logic [TAG_W-1:0]          r_tag  [NS];
  logic [DATA_W-1:0]         r_data [NS];

  logic                      w_last_vld;
  logic [TAG_W-1:0]          w_last_tag;
  logic [DATA_W-1:0]         w_last_data;

  logic [NUM_CH-1:0]         r_out_valid;
  logic [NUM_CH*DATA_W-1:0]  r_out_data;

  // Rotate eligibility so index 0 is the channel at rr_ptr, then take the first set bit.
  always_comb begin
    w_elig      = in_valid & ~flush & {NUM_CH{~reset}};
    w_rot       = {w_elig, w_elig} >> r_rr_ptr;
    w_grant     = '0;
    w_any_grant = 1'b0;
    w_pos       = '0;
    w_gnt_idx   = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (!w_any_grant && w_rot[off]) begin
        w_any_grant = 1'b1;
        w_pos       = {1'b0, r_rr_ptr} + (TAG_W+1)'(off);
        if (w_pos >= (TAG_W+1)'(NUM_CH)) begin
          w_pos = w_pos - (TAG_W+1)'(NUM_CH);
        end
        w_gnt_idx = w_pos[TAG_W-1:0];
      end
    end
    w_gnt_data = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_any_grant && (w_gnt_idx == TAG_W'(ch))) begin
        w_grant[ch] = 1'b1;
        w_gnt_data  = in_data[ch*DATA_W +: DATA_W];
      end
    end
    w_gnt_sum = w_gnt_data + DATA_W'(ADD_CONST);
  end

  assign stall = w_elig & ~w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_any_grant) begin
      r_rr_ptr <= (w_gnt_idx == TAG_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
    end
  end

  // A flush clears matching entries as they move forward; data/tag need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= (DEPTH > 1) && w_any_grant;
      for (int s = 1; s < NS; s++) begin
        r_vld[s] <= r_vld[s-1] & ~flush[r_tag[s-1]];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tag[0]  <= w_gnt_idx;
    r_data[0] <= w_gnt_sum;
    for (int s = 1; s < NS; s++) begin
      r_tag[s]  <= r_tag[s-1];
      r_data[s] <= r_data[s-1];
    end
  end

  always_comb begin
    if (DEPTH > 1) begin
      w_last_vld  = r_vld[NS-1];
      w_last_tag  = r_tag[NS-1];
      w_last_data = r_data[NS-1];
    end else begin
      w_last_vld  = w_any_grant;
      w_last_tag  = w_gnt_idx;
      w_last_data = w_gnt_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_last_vld && (w_last_tag == TAG_W'(k)) && !flush[k]) begin
          r_out_valid[k]                  <= 1'b1;
          r_out_data[k*DATA_W +: DATA_W]  <= w_last_data;
        end else begin
          r_out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (DEPTH > 1) ? |r_vld : 1'b0;

`ifdef SHARED_PIPE_STALL_CNT_EN
  logic [NUM_CH*16-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stall[i] && (r_stall_cnt[i*16 +: 16] != 16'hFFFF)) begin
          r_stall_cnt[i*16 +: 16] <= r_stall_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_shared_pipe_arbiter.sv
// tb/tb_shared_pipe_arbiter.sv - scoreboard bench for shared_pipe_arbiter (NUM_CH=2, DEPTH=3)
module tb_shared_pipe_arbiter;

  localparam int NUM_CH    = 2;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 3;
  localparam int ADD_CONST = 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_CH*DATA_W-1:0]  in_data;
  logic [NUM_CH-1:0]         in_valid;
  logic [NUM_CH-1:0]         flush;
  logic [NUM_CH-1:0]         stall;
  logic [NUM_CH*DATA_W-1:0]  out_data;
  logic [NUM_CH-1:0]         out_valid;
  logic                      busy;
`ifdef SHARED_PIPE_STALL_CNT_EN
  logic [NUM_CH*16-1:0]      stall_cnt;
`endif

  shared_pipe_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADD_CONST(ADD_CONST)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .flush(flush), .stall(stall), .out_data(out_data), .out_valid(out_valid),
    .busy(busy)
`ifdef SHARED_PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          ch;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input int due, input int ch, input logic [31:0] data);
    exp_t e;
    e.due  = due;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every output pulse must match the oldest expectation for its channel.
  always @(negedge clk) begin
    int idx;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (out_valid[ch] === 1'b1) begin
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (idx < 0 && exp_q[k].ch == ch) idx = k;
        end
        checks++;
        if (idx < 0) begin
          failures++;
          $display("FAIL out_unexpected ch=%0d cyc=%0d got data=%h, required no pulse",
                   ch, cyc, out_data[ch*DATA_W +: DATA_W]);
        end else begin
          if (exp_q[idx].due != cyc || out_data[ch*DATA_W +: DATA_W] !== exp_q[idx].data) begin
            failures++;
            $display("FAIL out_match ch=%0d got cyc=%0d data=%h, required cyc=%0d data=%h",
                     ch, cyc, out_data[ch*DATA_W +: DATA_W], exp_q[idx].due, exp_q[idx].data);
          end
          exp_q.delete(idx);
        end
      end
    end
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL out_missing ch=%0d got no pulse, required cyc=%0d data=%h",
                 exp_q[k].ch, exp_q[k].due, exp_q[k].data);
        exp_q.delete(k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    flush    = '0;
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = '0;
    flush    = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 2'b11;
    flush    = '0;
    in_data  = {32'h1234_5678, 32'h9abc_def0};
    #1;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if (stall !== 2'b00) begin
        failures++;
        $display("FAIL reset_stall got=%b required=00", stall);
      end
      checks++;
      if (out_valid !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got out_valid=%b busy=%b required 00/0", out_valid, busy);
      end
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_out_data got=%h required=0", out_data);
    end
    reset    = 1'b0;
    in_valid = '0;
  endtask

  // Runs straight after reset, so ch0 winning first also confirms rr_ptr==0.
  task automatic test_contention();
    int c0;
    c0 = cyc;
    in_valid = 2'b11;
    in_data  = {32'h0000_000B, 32'h0000_000A};
    #1;
    checks++;
    if (stall !== 2'b10) begin
      failures++;
      $display("FAIL contention_stall0 got=%b required=10", stall);
    end
    push_exp(c0 + 3, 0, 32'h0000_000B);
    tick();
    in_valid = 2'b10;
    #1;
    checks++;
    if (stall !== 2'b00) begin
      failures++;
      $display("FAIL contention_stall1 got=%b required=00", stall);
    end
    push_exp(c0 + 4, 1, 32'h0000_000C);
    tick();
    idle(5);
  endtask

  task automatic test_single();
    int c0;
    c0 = cyc;
    in_valid = 2'b01;
    in_data  = {32'h0, 32'h0000_0010};
    #1;
    checks++;
    if (stall[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_stall got=%b required=0", stall[0]);
    end
    push_exp(c0 + 3, 0, 32'h0000_0011);
    tick();
    in_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy got=%b required=1", busy);
    end
    idle(5);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_busy got=%b required=0", busy);
    end
  endtask

  task automatic test_flush_mid();
    int c0;
    c0 = cyc;
    in_valid = 2'b10;
    in_data  = {32'h0000_0005, 32'h0};
    tick();
    in_valid = 2'b01;
    flush    = 2'b10;
    in_data  = {32'h0, 32'h0000_0020};
    #1;
    checks++;
    if (stall !== 2'b00) begin
      failures++;
      $display("FAIL flush_mid_stall got=%b required=00", stall);
    end
    push_exp(c0 + 4, 0, 32'h0000_0021);
    tick();
    idle(6);
  endtask

  task automatic test_flush_last();
    in_valid = 2'b01;
    in_data  = {32'h0, 32'h0000_0077};
    tick();
    in_valid = '0;
    tick();
    flush = 2'b01;
    tick();
    flush = '0;
    idle(4);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_last_busy got=%b required=0", busy);
    end
  endtask

  task automatic test_flush_same_cycle();
    int c0;
    in_valid = 2'b01;
    flush    = 2'b01;
    in_data  = {32'h0, 32'h0000_0033};
    #1;
    checks++;
    if (stall !== 2'b00) begin
      failures++;
      $display("FAIL same_cycle_stall got=%b required=00", stall);
    end
    tick();
    in_valid = '0;
    flush    = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_busy got=%b required=0", busy);
    end
    c0 = cyc;
    in_valid = 2'b11;
    flush    = 2'b01;
    in_data  = {32'h0000_0044, 32'h0000_0055};
    #1;
    checks++;
    if (stall !== 2'b00) begin
      failures++;
      $display("FAIL flush_other_stall got=%b required=00", stall);
    end
    push_exp(c0 + 3, 1, 32'h0000_0045);
    tick();
    idle(5);
  endtask

  task automatic test_wrap();
    int c0;
    c0 = cyc;
    in_valid = 2'b01;
    in_data  = {32'h0, 32'hFFFF_FFFF};
    push_exp(c0 + 3, 0, 32'h0000_0000);
    tick();
    in_valid = 2'b10;
    in_data  = {32'hFFFF_FFFE, 32'h0};
    push_exp(c0 + 4, 1, 32'hFFFF_FFFF);
    tick();
    idle(5);
  endtask

  task automatic test_back_to_back();
    int          cnt [NUM_CH];
    int          g;
    logic [31:0] d;
    for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] = 0;
    for (int k = 0; k < 10; k++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        d = 32'h100 * (ch + 1) + cnt[ch];
        in_data[ch*DATA_W +: DATA_W] = d;
      end
      in_valid = 2'b11;
      g = k % NUM_CH;
      #1;
      checks++;
      if (stall !== ((g == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL b2b_stall k=%0d got=%b required=%b", k, stall, (g == 0) ? 2'b10 : 2'b01);
      end
      d = 32'h100 * (g + 1) + cnt[g] + ADD_CONST;
      push_exp(cyc + 3, g, d);
      cnt[g]++;
      tick();
    end
    idle(5);
`ifdef SHARED_PIPE_STALL_CNT_EN
    checks++;
    if (stall_cnt[16 +: 16] !== 16'd5 || stall_cnt[0 +: 16] !== 16'd5) begin
      failures++;
      $display("FAIL stall_cnt got ch1=%0d ch0=%0d required 5/5", stall_cnt[16 +: 16], stall_cnt[0 +: 16]);
    end
    apply_reset();
    checks++;
    if (stall_cnt !== '0) begin
      failures++;
      $display("FAIL stall_cnt_reset got=%h required=0", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = cyc;
    in_valid = 2'b01;
    in_data  = {32'h0000_0002, 32'h0000_0001};
    push_exp(c0 + 3, 0, 32'h0000_0002);
    tick();
    in_valid = 2'b10;
    tick();
    in_valid = 2'b01;
    tick();
    in_valid = '0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy got=%b required=0", busy);
    end
    idle(6);
  endtask

  initial begin
    in_data  = '0;
    in_valid = '0;
    flush    = '0;
    reset    = 1'b1;
    test_reset();
    test_contention();
    test_single();
    test_flush_mid();
    test_flush_last();
    test_flush_same_cycle();
    test_wrap();
    apply_reset();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
